// File: rtl/swerv_types.sv
// Shared types for the non-blocking load tag CAM.
// Entry record and register-file write packet.
package swerv_types;

    typedef struct packed {
        logic       valid;
        logic       wb;
        logic       stale;
        logic [4:0] rd;
    } nbl_cam_entry_t;

    typedef struct packed {
        logic       en;
        logic [4:0] rd;
    } nbl_wr_pkt_t;

endpackage

// File: rtl/nbl_free_pick.sv
// Lowest-index free entry picker.
// Ready when at least one entry is invalid.
module nbl_free_pick #(
    parameter int DEPTH = 4,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             ready_o
);

    // scan high to low so the lowest free index wins
    always_comb begin
        tag_o   = '0;
        ready_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                tag_o   = TAG_W'(i);
                ready_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nbload_tag_cam.sv
// Tracking CAM for outstanding non-blocking loads.
// Grants tags, flags dependent sources, drives RF writes on return.
module nbload_tag_cam
    import swerv_types::*;
#(
    parameter int DEPTH      = 4,
    parameter int TAG_W      = $clog2(DEPTH),
    parameter int NUM_LOOKUP = 4
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       alloc_valid,
    input  logic [4:0]                 alloc_rd,
    output logic                       alloc_ready,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic                       commit_valid,
    input  logic [TAG_W-1:0]           commit_tag,
    input  logic                       flush,
    input  logic                       ret_valid,
    input  logic [TAG_W-1:0]           ret_tag,
    input  logic [NUM_LOOKUP-1:0][4:0] lk_rs,
    output logic [NUM_LOOKUP-1:0]      lk_hit,
    output logic                       wr_en,
    output logic [4:0]                 wr_rd,
    output logic [TAG_W:0]             count,
    output logic                       full,
    output logic                       proto_err
);

    localparam int CW = TAG_W + 1;

    nbl_cam_entry_t [DEPTH-1:0] ent_q, ent_d;
    nbl_wr_pkt_t                wr_q, wr_d;
    logic                       perr_q, perr_d;
    logic [DEPTH-1:0]           valid_vec;
    logic                       alloc_fire;
    nbl_cam_entry_t             ret_e;

    nbl_free_pick #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_pick (
        .valid_i (valid_vec),
        .tag_o   (alloc_tag),
        .ready_o (alloc_ready)
    );

    // occupancy from registered state
    always_comb begin
        valid_vec = '0;
        count     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            count        = count + CW'(ent_q[i].valid);
        end
    end

    assign full       = (count == CW'(DEPTH));
    assign alloc_fire = alloc_valid & alloc_ready & ~flush;

    // entry update: commit beats flush, return frees, alloc fills a free slot
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && commit_tag == TAG_W'(i) && ent_q[i].valid)
                ent_d[i].wb = 1'b1;
            if (flush && !ent_d[i].wb)
                ent_d[i].valid = 1'b0;
            if (alloc_fire && alloc_rd != 5'd0 && ent_d[i].valid &&
                ent_d[i].rd == alloc_rd)
                ent_d[i].stale = 1'b1;
            if (ret_valid && ret_tag == TAG_W'(i))
                ent_d[i].valid = 1'b0;
            if (alloc_fire && alloc_tag == TAG_W'(i)) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].wb    = 1'b0;
                ent_d[i].stale = 1'b0;
                ent_d[i].rd    = alloc_rd;
            end
        end
    end

    // return decode from pre-edge entry state
    always_comb begin
        ret_e  = '0;
        wr_d   = '{en: 1'b0, rd: wr_q.rd};
        perr_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ret_tag == TAG_W'(i))
                ret_e = ent_q[i];
        end
        if (ret_valid) begin
            if (ret_e.valid && ret_e.wb) begin
                wr_d.en = ~ret_e.stale & (ret_e.rd != 5'd0);
                if (wr_d.en)
                    wr_d.rd = ret_e.rd;
            end else begin
                perr_d = 1'b1;
            end
        end
    end

    // source dependency check against live, non-superseded entries
    always_comb begin
        lk_hit = '0;
        for (int k = 0; k < NUM_LOOKUP; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid && !ent_q[i].stale &&
                    ent_q[i].rd == lk_rs[k] && lk_rs[k] != 5'd0)
                    lk_hit[k] = 1'b1;
            end
        end
    end

    // state and write-port registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ent_q  <= '0;
            wr_q   <= '0;
            perr_q <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            wr_q   <= wr_d;
            perr_q <= perr_d;
        end
    end

    assign wr_en     = wr_q.en;
    assign wr_rd     = wr_q.rd;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_nbload_tag_cam.sv
// Testbench for nbload_tag_cam.
// Directed scenarios then random traffic against a reference model.
module tb_nbload_tag_cam;

    localparam int DEPTH = 4;
    localparam int TW    = 2;
    localparam int NL    = 4;

    logic                clk = 1'b0;
    logic                rst_l = 1'b0;
    logic                alloc_valid = 1'b0;
    logic [4:0]          alloc_rd = '0;
    logic                alloc_ready;
    logic [TW-1:0]       alloc_tag;
    logic                commit_valid = 1'b0;
    logic [TW-1:0]       commit_tag = '0;
    logic                flush = 1'b0;
    logic                ret_valid = 1'b0;
    logic [TW-1:0]       ret_tag = '0;
    logic [NL-1:0][4:0]  lk_rs = '0;
    logic [NL-1:0]       lk_hit;
    logic                wr_en;
    logic [4:0]          wr_rd;
    logic [TW:0]         count;
    logic                full;
    logic                proto_err;

    always #5 clk = ~clk;

    nbload_tag_cam #(
        .DEPTH      (DEPTH),
        .TAG_W      (TW),
        .NUM_LOOKUP (NL)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .flush        (flush),
        .ret_valid    (ret_valid),
        .ret_tag      (ret_tag),
        .lk_rs        (lk_rs),
        .lk_hit       (lk_hit),
        .wr_en        (wr_en),
        .wr_rd        (wr_rd),
        .count        (count),
        .full         (full),
        .proto_err    (proto_err)
    );

    // reference model: outstanding loads per tag
    bit         mv  [DEPTH];
    bit         mwb [DEPTH];
    bit         mst [DEPTH];
    logic [4:0] mrd [DEPTH];
    bit         mwe;
    logic [4:0] mwrd;
    bit         mperr;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(mv[i]);
        return c;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < DEPTH; i++)
            if (!mv[i]) return i;
        return DEPTH;
    endfunction

    function automatic logic [NL-1:0] m_hits();
        logic [NL-1:0] h = '0;
        for (int k = 0; k < NL; k++)
            for (int i = 0; i < DEPTH; i++)
                if (lk_rs[k] != 0 && mv[i] && !mst[i] && mrd[i] == lk_rs[k])
                    h[k] = 1'b1;
        return h;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 0; mwb[i] = 0; mst[i] = 0; mrd[i] = '0;
        end
        mwe = 0; mwrd = '0; mperr = 0;
    endtask

    task automatic check_outs();
        chk("count", 32'(count), 32'(m_count()));
        chk("full", 32'(full), 32'(m_count() == DEPTH));
        chk("alloc_ready", 32'(alloc_ready), 32'(m_free() < DEPTH));
        if (m_free() < DEPTH)
            chk("alloc_tag", 32'(alloc_tag), 32'(m_free()));
        chk("wr_en", 32'(wr_en), 32'(mwe));
        chk("wr_rd", 32'(wr_rd), 32'(mwrd));
        chk("proto_err", 32'(proto_err), 32'(mperr));
        chk("lk_hit", 32'(lk_hit), 32'(m_hits()));
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        #1;
        m_clear();
        check_outs();
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic step(bit av, logic [4:0] ard, bit cv, logic [TW-1:0] ct,
                        bit fl, bit rv, logic [TW-1:0] rt);
        bit         nv  [DEPTH];
        bit         nwb [DEPTH];
        bit         nst [DEPTH];
        logic [4:0] nrd [DEPTH];
        int         ft;
        bit         doa;
        @(negedge clk);
        alloc_valid  = av;
        alloc_rd     = ard;
        commit_valid = cv;
        commit_tag   = ct;
        flush        = fl;
        ret_valid    = rv;
        ret_tag      = rt;
        for (int k = 0; k < NL; k++) lk_rs[k] = 5'($urandom_range(0, 7));
        #1;
        chk("lk_hit_pre", 32'(lk_hit), 32'(m_hits()));
        ft  = m_free();
        doa = av && ft < DEPTH && !fl;
        nv = mv; nwb = mwb; nst = mst; nrd = mrd;
        mwe = 0; mperr = 0;
        if (rv) begin
            if (mv[rt] && mwb[rt]) begin
                mwe = !mst[rt] && mrd[rt] != 0;
                if (mwe) mwrd = mrd[rt];
            end else begin
                mperr = 1;
            end
        end
        if (cv && mv[ct]) nwb[ct] = 1;
        if (fl)
            for (int i = 0; i < DEPTH; i++)
                if (!nwb[i]) nv[i] = 0;
        if (doa && ard != 0)
            for (int i = 0; i < DEPTH; i++)
                if (nv[i] && nrd[i] == ard) nst[i] = 1;
        if (rv) nv[rt] = 0;
        if (doa) begin
            nv[ft] = 1; nwb[ft] = 0; nst[ft] = 0; nrd[ft] = ard;
        end
        @(posedge clk);
        #1;
        mv = nv; mwb = nwb; mst = nst; mrd = nrd;
        check_outs();
        alloc_valid  = 1'b0;
        commit_valid = 1'b0;
        flush        = 1'b0;
        ret_valid    = 1'b0;
    endtask

    initial begin
        m_clear();
        #3;
        check_outs();
        @(negedge clk);
        rst_l = 1'b1;

        // basic alloc / commit / return
        step(1, 5'd5, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2'd0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'd0);
        chk("basic_wr_en", 32'(wr_en), 32'd1);
        chk("basic_wr_rd", 32'(wr_rd), 32'd5);
        do_reset();

        // fill, ignored overflow, recycle tag 2
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 0, 0, 0, 0, 0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        step(1, 5'd9, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2'd2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'd2);
        chk("recycle_tag", 32'(alloc_tag), 32'd2);
        step(1, 5'd10, 0, 0, 0, 0, 0);
        do_reset();

        // write-after-write
        step(1, 5'd7, 0, 0, 0, 0, 0);
        step(1, 5'd7, 1, 2'd0, 0, 0, 0);
        step(0, 0, 1, 2'd1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'd0);
        chk("waw_old_wr", 32'(wr_en), 32'd0);
        step(0, 0, 0, 0, 0, 1, 2'd1);
        chk("waw_new_wr", 32'(wr_en), 32'd1);
        do_reset();

        // flush keeps committed entries only
        step(1, 5'd11, 0, 0, 0, 0, 0);
        step(1, 5'd12, 1, 2'd0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("flush_count", 32'(count), 32'd1);
        lk_rs = {5'd0, 5'd12, 5'd11, 5'd0};
        #1;
        chk("flush_lk", 32'(lk_hit), 32'b0010);
        // commit racing flush, then bogus returns
        step(1, 5'd13, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2'd1, 1, 0, 0);
        chk("commit_flush", 32'(count), 32'd2);
        step(0, 0, 0, 0, 0, 1, 2'd3);
        chk("perr_pulse", 32'(proto_err), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 5'd14, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2'd2, 0, 1, 2'd2);
        chk("ret_commit_perr", 32'(proto_err), 32'd1);
        do_reset();

        // x0 destination never writes
        step(1, 5'd0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2'd0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'd0);
        chk("x0_wr", 32'(wr_en), 32'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, TW'($urandom_range(0, 3)),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0, TW'($urandom_range(0, 3)));
        end

        // async reset cancels a pending write
        do_reset();
        step(1, 5'd9, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2'd0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'd0);
        chk("pre_rst_wr", 32'(wr_en), 32'd1);
        #1;
        do_reset();
        chk("rst_wr_rd", 32'(wr_rd), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/nbload_tag_cam.md
# nbload_tag_cam

Parametrised tracking CAM for outstanding non-blocking loads, generalising the single-entry `{valid, wb, tag, rd}` load-CAM record to DEPTH entries with multiple dependency-lookup ports and write-after-write cancellation. It sits in the decode stage between LSU issue, commit and the LSU data-return bus. It hands out load tags, stalls dependent reads while a load is in flight, and emits the integer register-file write enable/address when data returns.

## Interface
- `DEPTH`, 4: number of CAM entries (≥2).
- `TAG_W`, $clog2(DEPTH): tag width.
- `NUM_LOOKUP`, 4: number of source-register lookup ports.
- `clk`  in  1  core clock.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `alloc_valid`  in  1  allocate an entry for an issuing load.
- `alloc_rd`  in  5  load destination register.
- `alloc_ready`  out  1  a free entry exists (from registered state).
- `alloc_tag`  out  TAG_W  tag granted: lowest-index free entry.
- `commit_valid`  in  1  load has reached writeback unflushed.
- `commit_tag`  in  TAG_W  entry to commit.
- `flush`  in  1  pipeline flush; kills uncommitted entries.
- `ret_valid`  in  1  LSU data return.
- `ret_tag`  in  TAG_W  returning entry.
- `lk_rs`  in  NUM_LOOKUP×5  source registers to check.
- `lk_hit`  out  NUM_LOOKUP  source pending on an in-flight load.
- `wr_en`  out  1  register-file write enable (registered).
- `wr_rd`  out  5  register-file write address (registered).
- `count`  out  TAG_W+1  valid entries.
- `full`  out  1  all entries valid.
- `proto_err`  out  1  one-cycle pulse on an illegal return.

## Operation
- Entry state: `valid`, `wb` (committed), `stale` (superseded by a younger write to the same rd), `rd[4:0]`.
- Allocate when `alloc_valid & alloc_ready & ~flush`: entry at `alloc_tag` ← {valid=1, wb=0, stale=0, rd}. `alloc_valid` while `~alloc_ready` is ignored; the producer must stall.
- WAW: on allocation, every other valid entry with equal rd (rd≠0) gets `stale`=1.
- Commit: `commit_valid` on a valid entry sets `wb`=1. Commit to an invalid entry is ignored.
- Flush: clears `valid` on every entry with `wb`=0. Committed entries survive.
- Return on a valid entry frees it.
  - Next cycle `wr_en`=`wb & ~stale & rd≠0` and `wr_rd`=rd.
  - If the entry had `wb`=0, or the return targets an invalid entry: no write, `proto_err` pulses next cycle, and the entry (if valid) is freed.
- Lookup (combinational): `lk_hit[i]` = OR over valid, non-stale entries of (rd==lk_rs[i]) with lk_rs[i]≠0.
- `wr_rd` holds its last value when `wr_en`=0.

## Timing
- Reset values: all entries invalid, `wr_en`=0, `wr_rd`=0, `proto_err`=0, `count`=0, `full`=0, `alloc_ready`=1, `alloc_tag`=0.
- Allocate, commit, flush and the entry free on return update state at the clock edge. Lookups reflect the new state the following cycle.
- `wr_en`/`wr_rd`/`proto_err` have 1-cycle latency from `ret_valid`.
- Same-cycle priorities:
  - Return freeing an entry does not make it allocatable that cycle.
  - Commit and flush on the same entry: commit wins, entry survives.
  - Flush with `alloc_valid`: the allocation is dropped.
  - Return and lookup of the same rd: `lk_hit` still asserted (pre-edge state).
  - Return and commit on the same tag: treated as uncommitted, so `proto_err` pulses.
- Full: `alloc_ready`=0 and `full`=1 while `count`=DEPTH. They deassert the cycle after any free.
- Reset mid-operation clears all entries and cancels any pending `wr_en` immediately (asynchronous).

## Structure
- Shared package `swerv_types` gains `nbl_cam_entry_t` {valid, wb, stale, rd[4:0]} and `nbl_wr_pkt_t` {en, rd[4:0]}.
- Sub-module `nbl_free_pick`: parametrised lowest-index-free priority encoder producing `alloc_tag` and `alloc_ready` from the valid vector.
- Entry array is flops only, with no SRAM.

## Test plan
- Reset, then alloc rd=5 → tag 0. Commit tag 0, return tag 0 → next cycle `wr_en`=1, `wr_rd`=5, `count` back to 0.
- DEPTH=4: four allocs rd=1..4 → `full`=1, `alloc_ready`=0. A fifth alloc is ignored. Return tag 2 after commit → the next alloc gets tag 2.
- WAW: alloc rd=7 (tag 0), then alloc rd=7 (tag 1), commit both. Return tag 0 → `wr_en`=0. Return tag 1 → `wr_en`=1, `wr_rd`=7.
- Flush: tags 0 and 1 allocated, only tag 0 committed, `flush` → `count`=1. `lk_rs`=rd of tag 1 → `lk_hit`=0. `lk_rs`=rd of tag 0 → `lk_hit`=1.
- Same cycle commit tag 0 + flush → tag 0 survives. Return tag 3 (invalid) → `proto_err` pulses once, no write.
- Alloc rd=0, commit, return → `wr_en`=0. `lk_rs`=0 → `lk_hit`=0 throughout. Assert `rst_l` low mid-stream → all outputs at reset values.
